// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard status inputs and pipeline load/flush controls.
// "slave" is the controller side, "master" is the pipeline/driver side.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
);
    logic                  imem_stall_i;
    logic                  dmem_stall_i;
    logic                  ex_mispredict_i;
    logic                  ex_is_load_i;
    logic [REG_ADDR_W-1:0] ex_rd_i;
    logic [REG_ADDR_W-1:0] id_rs1_i;
    logic [REG_ADDR_W-1:0] id_rs2_i;
    logic                  id_uses_rs1_i;
    logic                  id_uses_rs2_i;
    logic                  pc_load_o;
    logic                  if_id_load_o;
    logic                  if_id_flush_o;
    logic                  id_ex_load_o;
    logic                  id_ex_flush_o;
    logic                  ex_mem_load_o;
    logic                  mem_wb_load_o;
    logic                  in_drain_o;
    logic [CNT_W-1:0]      stall_cnt_o;
    logic [CNT_W-1:0]      flush_cnt_o;

    modport slave (
        input  imem_stall_i, dmem_stall_i, ex_mispredict_i, ex_is_load_i,
               ex_rd_i, id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
        output pc_load_o, if_id_load_o, if_id_flush_o, id_ex_load_o, id_ex_flush_o,
               ex_mem_load_o, mem_wb_load_o, in_drain_o, stall_cnt_o, flush_cnt_o
    );

    modport master (
        output imem_stall_i, dmem_stall_i, ex_mispredict_i, ex_is_load_i,
               ex_rd_i, id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
        input  pc_load_o, if_id_load_o, if_id_flush_o, id_ex_load_o, id_ex_flush_o,
               ex_mem_load_o, mem_wb_load_o, in_drain_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory stalls, load-use bubbles,
// mispredict redirects with a DRAIN state for an outstanding wrong-path fetch.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  hz
);
    typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;
    logic [REG_ADDR_W-1:0] w_ex_rd;
    logic                  w_load_use;
    logic                  w_redirect;
    logic                  w_pc_load;
    logic                  w_if_id_load;
    logic                  w_if_id_flush;
    logic                  w_id_ex_load;
    logic                  w_id_ex_flush;
    logic                  w_ex_mem_load;
    logic                  w_mem_wb_load;

    assign w_ex_rd    = hz.ex_rd_i;
    assign w_load_use = hz.ex_is_load_i && (w_ex_rd != '0) &&
                        ((hz.id_uses_rs1_i && (hz.id_rs1_i == w_ex_rd)) ||
                         (hz.id_uses_rs2_i && (hz.id_rs2_i == w_ex_rd)));

    always_comb begin
        w_next_state  = r_state;
        w_redirect    = 1'b0;
        w_pc_load     = 1'b0;
        w_if_id_load  = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_load  = 1'b0;
        w_id_ex_flush = 1'b0;
        w_ex_mem_load = 1'b0;
        w_mem_wb_load = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_RUN: begin
                    if (hz.dmem_stall_i || (hz.imem_stall_i && !hz.ex_mispredict_i)) begin
                        // Full freeze; a pending mispredict persists because EX is frozen.
                    end else if (hz.ex_mispredict_i) begin
                        w_redirect    = 1'b1;
                        w_pc_load     = 1'b1;
                        w_if_id_flush = 1'b1;
                        w_id_ex_flush = 1'b1;
                        w_ex_mem_load = 1'b1;
                        w_mem_wb_load = 1'b1;
                        if (hz.imem_stall_i) w_next_state = ST_DRAIN;
                    end else if (w_load_use) begin
                        w_id_ex_flush = 1'b1;
                        w_ex_mem_load = 1'b1;
                        w_mem_wb_load = 1'b1;
                    end else begin
                        w_pc_load     = 1'b1;
                        w_if_id_load  = 1'b1;
                        w_id_ex_load  = 1'b1;
                        w_ex_mem_load = 1'b1;
                        w_mem_wb_load = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // The exit cycle keeps DRAIN outputs so the returning wrong-path word is dropped.
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                    w_ex_mem_load = !hz.dmem_stall_i;
                    w_mem_wb_load = !hz.dmem_stall_i;
                    if (!hz.imem_stall_i) w_next_state = ST_RUN;
                end
                default: w_next_state = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (!w_pc_load && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_redirect && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign hz.pc_load_o     = w_pc_load;
    assign hz.if_id_load_o  = w_if_id_load;
    assign hz.if_id_flush_o = w_if_id_flush;
    assign hz.id_ex_load_o  = w_id_ex_load;
    assign hz.id_ex_flush_o = w_id_ex_flush;
    assign hz.ex_mem_load_o = w_ex_mem_load;
    assign hz.mem_wb_load_o = w_mem_wb_load;
    assign hz.in_drain_o    = !rst && (r_state == ST_DRAIN);
    assign hz.stall_cnt_o   = r_stall_cnt;
    assign hz.flush_cnt_o   = r_flush_cnt;
endmodule
